// File: rtl/NXConstants.sv
// Shared encodings for the control host and the controller it drives.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package NXConstants;

   localparam int MESSAGE_WIDTH = 32;

   // Command opcodes carried in the upper bits of every control message.
   typedef enum logic [3:0] {
      CMD_ID       = 4'd0,
      CMD_VERSION  = 4'd1,
      CMD_PARAM    = 4'd2,
      CMD_INTERVAL = 4'd3,
      CMD_ACTIVE   = 4'd4,
      CMD_STATUS   = 4'd5,
      CMD_CYCLES   = 4'd6
   } control_command_t;

   localparam int PAYLOAD_WIDTH = MESSAGE_WIDTH - $bits(control_command_t);

   typedef struct packed {
      control_command_t           command;
      logic [PAYLOAD_WIDTH-1:0]   payload;
   } control_message_t;

   typedef logic [MESSAGE_WIDTH-1:0] control_response_t;

   // PARAM payload selects which mesh dimension is read back.
   localparam logic [PAYLOAD_WIDTH-1:0] PARAM_ROWS    = '0;
   localparam logic [PAYLOAD_WIDTH-1:0] PARAM_COLUMNS = PAYLOAD_WIDTH'(1);

   // Only the low 24 bits identify the device; the top byte is revision.
   localparam logic [MESSAGE_WIDTH-1:0] HW_DEV_ID = 32'h004E_5843;

   // Bit of the STATUS response that reports the mesh is still running.
   localparam int STATUS_ACTIVE_BIT = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEND     = 3'd1,
      ST_WAIT_RSP = 3'd2,
      ST_POLL_GAP = 3'd3,
      ST_DONE     = 3'd4,
      ST_ERROR    = 3'd5
   } host_state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_BAD_ID   = 2'd1,
      ERR_TIMEOUT  = 2'd2,
      ERR_ZERO_RUN = 2'd3
   } error_code_t;

endpackage

// File: rtl/nx_control_host.sv
// Control host: identifies the mesh, reads its size, programs a run, polls
// until idle and reads back the cycle count. Latency: one command per
// accepted handshake, responses awaited up to TIMEOUT cycles.
// Backpressure: cmd held stable until cmd_ready_i; rsp_ready_o only in WAIT_RSP.
//
// Ports:
//   clk_i, rst_i            clock, async active-low reset
//   start_i, run_cycles_i   kick off a run with the given interval
//   cmd_data_o/valid/ready  command channel to the controller
//   rsp_data_i/valid/ready  response channel from the controller
//   busy_o, done_o, error_o, error_code_o   run status
//   rows_o, columns_o, cycles_o             values read back from the mesh
module nx_control_host
   import NXConstants::*;
#(
   parameter int TIMEOUT  = 1024,
   parameter int POLL_GAP = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic [PAYLOAD_WIDTH-1:0]  run_cycles_i,
   output control_message_t          cmd_data_o,
   output logic                      cmd_valid_o,
   input  logic                      cmd_ready_i,
   input  control_response_t         rsp_data_i,
   input  logic                      rsp_valid_i,
   output logic                      rsp_ready_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      error_o,
   output logic [1:0]                error_code_o,
   output logic [7:0]                rows_o,
   output logic [7:0]                columns_o,
   output logic [MESSAGE_WIDTH-1:0]  cycles_o
);

   // One counter serves both the response timeout and the poll gap.
   localparam int CNT_MAX = (TIMEOUT > POLL_GAP) ? TIMEOUT : POLL_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(POLL_GAP - 1);

   host_state_t               state_q;
   logic [2:0]                step_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [PAYLOAD_WIDTH-1:0]  run_q;

   logic [2:0]                nxt_step;
   control_message_t          nxt_cmd;

   // Maps a step index onto the message the controller expects.
   function automatic control_message_t build_cmd(input logic [2:0]               step,
                                                  input logic [PAYLOAD_WIDTH-1:0] rc);
      control_message_t m;
      m.command = CMD_ID;
      m.payload = '0;
      case (step)
         3'd0: m.command = CMD_ID;
         3'd1: m.command = CMD_VERSION;
         3'd2: begin m.command = CMD_PARAM;    m.payload = PARAM_ROWS;    end
         3'd3: begin m.command = CMD_PARAM;    m.payload = PARAM_COLUMNS; end
         3'd4: begin m.command = CMD_INTERVAL; m.payload = rc;            end
         3'd5: begin m.command = CMD_ACTIVE;   m.payload = PAYLOAD_WIDTH'(1); end
         3'd6: m.command = CMD_STATUS;
         default: m.command = CMD_CYCLES;
      endcase
      return m;
   endfunction

   always_comb begin
      nxt_step = step_q + 3'd1;
      nxt_cmd  = build_cmd(nxt_step, run_q);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= ST_IDLE;
         step_q       <= '0;
         cnt_q        <= '0;
         run_q        <= '0;
         cmd_data_o   <= '0;
         cmd_valid_o  <= 1'b0;
         rsp_ready_o  <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
         error_code_o <= ERR_NONE;
         rows_o       <= '0;
         columns_o    <= '0;
         cycles_o     <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start_i) begin
                  done_o       <= 1'b0;
                  error_o      <= 1'b0;
                  error_code_o <= ERR_NONE;
                  step_q       <= '0;
                  if (run_cycles_i == '0) begin
                     // Nothing to run: fail without touching the controller.
                     state_q      <= ST_ERROR;
                     error_o      <= 1'b1;
                     error_code_o <= ERR_ZERO_RUN;
                  end else begin
                     run_q       <= run_cycles_i;
                     state_q     <= ST_SEND;
                     cmd_data_o  <= build_cmd(3'd0, run_cycles_i);
                     cmd_valid_o <= 1'b1;
                     busy_o      <= 1'b1;
                  end
               end
            end

            ST_SEND: begin
               if (cmd_ready_i) begin
                  if (step_q == 3'd4 || step_q == 3'd5) begin
                     // INTERVAL and ACTIVE are fire-and-forget.
                     step_q     <= nxt_step;
                     cmd_data_o <= nxt_cmd;
                  end else begin
                     cmd_valid_o <= 1'b0;
                     rsp_ready_o <= 1'b1;
                     cnt_q       <= '0;
                     state_q     <= ST_WAIT_RSP;
                  end
               end
            end

            ST_WAIT_RSP: begin
               // A response in the final timeout cycle still counts.
               if (rsp_valid_i) begin
                  rsp_ready_o <= 1'b0;
                  cnt_q       <= '0;
                  case (step_q)
                     3'd0: begin
                        if (rsp_data_i[23:0] != HW_DEV_ID[23:0]) begin
                           state_q      <= ST_ERROR;
                           busy_o       <= 1'b0;
                           error_o      <= 1'b1;
                           error_code_o <= ERR_BAD_ID;
                        end else begin
                           state_q     <= ST_SEND;
                           step_q      <= nxt_step;
                           cmd_data_o  <= nxt_cmd;
                           cmd_valid_o <= 1'b1;
                        end
                     end
                     3'd6: begin
                        if (rsp_data_i[STATUS_ACTIVE_BIT]) begin
                           state_q <= ST_POLL_GAP;
                        end else begin
                           state_q     <= ST_SEND;
                           step_q      <= nxt_step;
                           cmd_data_o  <= nxt_cmd;
                           cmd_valid_o <= 1'b1;
                        end
                     end
                     3'd7: begin
                        cycles_o <= rsp_data_i;
                        state_q  <= ST_DONE;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                     end
                     default: begin
                        if (step_q == 3'd2) rows_o    <= rsp_data_i[7:0];
                        if (step_q == 3'd3) columns_o <= rsp_data_i[7:0];
                        state_q     <= ST_SEND;
                        step_q      <= nxt_step;
                        cmd_data_o  <= nxt_cmd;
                        cmd_valid_o <= 1'b1;
                     end
                  endcase
               end else if (cnt_q == TIMEOUT_LAST) begin
                  rsp_ready_o  <= 1'b0;
                  state_q      <= ST_ERROR;
                  busy_o       <= 1'b0;
                  error_o      <= 1'b1;
                  error_code_o <= ERR_TIMEOUT;
               end else if (cnt_q < TIMEOUT_LAST) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            ST_POLL_GAP: begin
               // cmd_data_o still holds STATUS from the previous poll.
               if (cnt_q >= GAP_LAST) begin
                  cnt_q       <= '0;
                  state_q     <= ST_SEND;
                  cmd_valid_o <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            default: begin
               state_q     <= ST_IDLE;
               cmd_valid_o <= 1'b0;
               rsp_ready_o <= 1'b0;
               busy_o      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nx_control_host.sv
// Bench for nx_control_host: scripted responder plus a queue of expected commands.
// Latency: responder answers on the second cycle rsp_ready_o is seen high.
// Backpressure: optional per-command cmd_ready_i stall.
module tb_nx_control_host;
   import NXConstants::*;

   localparam int TO  = 8;
   localparam int GAP = 4;

   logic                     clk = 1'b0;
   logic                     rst_i = 1'b0;
   logic                     start_i = 1'b0;
   logic [PAYLOAD_WIDTH-1:0] run_cycles_i = '0;
   control_message_t         cmd_data_o;
   logic                     cmd_valid_o;
   logic                     cmd_ready_i = 1'b0;
   control_response_t        rsp_data_i = '0;
   logic                     rsp_valid_i = 1'b0;
   logic                     rsp_ready_o;
   logic                     busy_o, done_o, error_o;
   logic [1:0]               error_code_o;
   logic [7:0]               rows_o, columns_o;
   logic [MESSAGE_WIDTH-1:0] cycles_o;

   always #5 clk = ~clk;

   nx_control_host #(.TIMEOUT(TO), .POLL_GAP(GAP)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .run_cycles_i(run_cycles_i),
      .cmd_data_o(cmd_data_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
      .rsp_data_i(rsp_data_i), .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .error_code_o(error_code_o),
      .rows_o(rows_o), .columns_o(columns_o), .cycles_o(cycles_o)
   );

   int n_checks = 0;
   int n_pass   = 0;
   control_message_t exp_q[$];

   // Responder configuration
   int          ready_stall     = 0;
   logic        silent_after_id = 1'b0;
   logic [31:0] id_resp         = HW_DEV_ID;
   logic [7:0]  rows_val        = 8'd3;
   logic [7:0]  cols_val        = 8'd3;
   int          active_polls    = 3;
   int          poke_start_at   = -1;
   logic        abort_on_status = 1'b0;

   int               status_seen;
   int               hi_run;
   int               last_hi;
   control_message_t last_cmd;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic control_message_t mk(input control_command_t c, input logic [PAYLOAD_WIDTH-1:0] p);
      control_message_t m;
      m.command = c;
      m.payload = p;
      return m;
   endfunction

   task automatic push_full_run(input logic [PAYLOAD_WIDTH-1:0] rc, input int polls);
      exp_q.push_back(mk(CMD_ID, '0));
      exp_q.push_back(mk(CMD_VERSION, '0));
      exp_q.push_back(mk(CMD_PARAM, PAYLOAD_WIDTH'(0)));
      exp_q.push_back(mk(CMD_PARAM, PAYLOAD_WIDTH'(1)));
      exp_q.push_back(mk(CMD_INTERVAL, rc));
      exp_q.push_back(mk(CMD_ACTIVE, PAYLOAD_WIDTH'(1)));
      for (int i = 0; i < polls; i++) exp_q.push_back(mk(CMD_STATUS, '0));
      exp_q.push_back(mk(CMD_CYCLES, '0));
   endtask

   task automatic pulse_start(input logic [PAYLOAD_WIDTH-1:0] rc);
      run_cycles_i = rc;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic do_reset_abort();
      cmd_ready_i = 1'b0;
      rsp_valid_i = 1'b0;
      rst_i = 1'b0;
      #1;
      check_eq("rst_cmd_valid", cmd_valid_o, 0);
      check_eq("rst_rsp_ready", rsp_ready_o, 0);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_flags", {done_o, error_o, error_code_o}, 0);
      check_eq("rst_rows_cols", {rows_o, columns_o}, 0);
      check_eq("rst_cycles", cycles_o, 0);
      tick();
      tick();
      rst_i = 1'b1;
   endtask

   task automatic run_seq(input int budget);
      int               stall = 0;
      bit               pend = 1'b0;
      control_message_t held = '0;
      int               cyc = 0;
      hi_run = 0;
      last_hi = 0;
      status_seen = 0;
      while (busy_o && cyc < budget) begin
         // command channel
         if (pend) begin
            check_eq("cmd_valid_held", cmd_valid_o, 1);
            check_eq("cmd_data_stable", cmd_data_o, held);
         end
         if (cmd_valid_o && stall < ready_stall) begin
            cmd_ready_i = 1'b0;
            stall++;
            pend = 1'b1;
            held = cmd_data_o;
         end else if (cmd_valid_o) begin
            cmd_ready_i = 1'b1;
            stall = 0;
            pend = 1'b0;
            if (exp_q.size() == 0) check_eq("cmd_unexpected", cmd_valid_o, 0);
            else check_eq("cmd_order", cmd_data_o, exp_q.pop_front());
            last_cmd = cmd_data_o;
         end else begin
            cmd_ready_i = 1'b0;
            pend = 1'b0;
         end
         // response channel
         rsp_valid_i = 1'b0;
         if (rsp_ready_o) begin
            hi_run++;
            if (abort_on_status && last_cmd.command == CMD_STATUS) begin
               do_reset_abort();
               return;
            end
            if (!(silent_after_id && last_cmd.command != CMD_ID) && hi_run >= 2) begin
               rsp_valid_i = 1'b1;
               case (last_cmd.command)
                  CMD_ID:     rsp_data_i = id_resp;
                  CMD_PARAM:  rsp_data_i = {24'h0, (last_cmd.payload == '0) ? rows_val : cols_val};
                  CMD_STATUS: begin
                     status_seen++;
                     rsp_data_i = (status_seen < active_polls) ? 32'h0000_0008 : 32'h0000_0000;
                  end
                  CMD_CYCLES: rsp_data_i = 32'd100;
                  default:    rsp_data_i = 32'h0000_0102;
               endcase
            end
         end else begin
            if (hi_run != 0) last_hi = hi_run;
            hi_run = 0;
         end
         start_i = (cyc == poke_start_at);
         tick();
         cyc++;
      end
      if (hi_run != 0) last_hi = hi_run;
      cmd_ready_i = 1'b0;
      rsp_valid_i = 1'b0;
      start_i = 1'b0;
      check_eq("seq_within_budget", busy_o, 0);
   endtask

   initial begin
      bit seen_valid;

      // Reset state, held before any clock edge.
      #3;
      check_eq("reset_outputs", {cmd_valid_o, rsp_ready_o, busy_o, done_o, error_o, error_code_o}, 0);
      check_eq("reset_readback", {rows_o, columns_o, cycles_o}, 0);
      tick();
      tick();
      rst_i = 1'b1;
      tick();
      check_eq("idle_after_release", {cmd_valid_o, busy_o}, 0);

      // Nominal run with a stray start while busy.
      push_full_run(PAYLOAD_WIDTH'(100), 3);
      pulse_start(PAYLOAD_WIDTH'(100));
      check_eq("busy_after_start", busy_o, 1);
      poke_start_at = 3;
      run_seq(600);
      poke_start_at = -1;
      check_eq("run1_done", {done_o, error_o}, 2'b10);
      check_eq("run1_rows", rows_o, 3);
      check_eq("run1_columns", columns_o, 3);
      check_eq("run1_cycles", cycles_o, 100);
      check_eq("run1_status_polls", status_seen, 3);
      check_eq("run1_queue_empty", exp_q.size(), 0);

      // Stalled command channel, different mesh size.
      ready_stall = 5;
      rows_val = 8'd5;
      cols_val = 8'd7;
      push_full_run(PAYLOAD_WIDTH'(1234), 3);
      pulse_start(PAYLOAD_WIDTH'(1234));
      check_eq("done_cleared_on_start", done_o, 0);
      run_seq(1500);
      check_eq("run2_done", {done_o, error_o}, 2'b10);
      check_eq("run2_rows_cols", {rows_o, columns_o}, {8'd5, 8'd7});
      check_eq("run2_queue_empty", exp_q.size(), 0);
      ready_stall = 0;

      // Zero interval: immediate error, no command.
      pulse_start('0);
      check_eq("zero_run_error", {error_o, error_code_o, done_o, busy_o}, {1'b1, 2'd3, 1'b0, 1'b0});
      seen_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         seen_valid |= cmd_valid_o;
         tick();
      end
      check_eq("zero_run_no_cmd", seen_valid, 0);

      // Wrong device ID.
      id_resp = 32'h0012_3456;
      exp_q.push_back(mk(CMD_ID, '0));
      pulse_start(PAYLOAD_WIDTH'(100));
      check_eq("error_cleared_on_start", error_o, 0);
      run_seq(200);
      check_eq("bad_id_error", {error_o, error_code_o}, {1'b1, 2'd1});
      check_eq("bad_id_queue_empty", exp_q.size(), 0);
      id_resp = HW_DEV_ID;

      // Silent controller after ID.
      silent_after_id = 1'b1;
      exp_q.push_back(mk(CMD_ID, '0));
      exp_q.push_back(mk(CMD_VERSION, '0));
      pulse_start(PAYLOAD_WIDTH'(100));
      run_seq(200);
      check_eq("timeout_error", {error_o, error_code_o}, {1'b1, 2'd2});
      check_eq("timeout_wait_cycles", last_hi, TO);
      check_eq("timeout_queue_empty", exp_q.size(), 0);
      silent_after_id = 1'b0;

      // Reset while waiting on the first STATUS response.
      rows_val = 8'd3;
      cols_val = 8'd3;
      abort_on_status = 1'b1;
      push_full_run(PAYLOAD_WIDTH'(100), 3);
      pulse_start(PAYLOAD_WIDTH'(100));
      run_seq(600);
      abort_on_status = 1'b0;
      exp_q.delete();
      seen_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         seen_valid |= cmd_valid_o | busy_o;
         tick();
      end
      check_eq("post_reset_quiet", seen_valid, 0);

      // Fresh start after the abort.
      push_full_run(PAYLOAD_WIDTH'(100), 3);
      pulse_start(PAYLOAD_WIDTH'(100));
      run_seq(600);
      check_eq("restart_done", {done_o, error_o}, 2'b10);
      check_eq("restart_cycles", cycles_o, 100);
      check_eq("restart_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
